// File: rtl/math_pkg.sv
// ============================================================================
//  Module      : math_pkg
//  Description : Shared state encodings and default widths for the sequential
//                math units (multiplier, calculator FSM, divider).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package math_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int MATH_MULT_DEFAULT_WIDTH = 8;

endpackage : math_pkg

`default_nettype wire

// File: rtl/math_multiplier_seq.sv
// ============================================================================
//  Module      : math_multiplier_seq
//  Description : Sequential shift-add unsigned multiplier, one partial product
//                per clock, start/busy/done handshake.
//                Optional early exit on exhausted multiplier:
//                MATH_MULT_EARLY_EXIT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module math_multiplier_seq
  import math_pkg::*;
#(
  parameter int WIDTH = MATH_MULT_DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   mulResult
);

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  state_e               state_q,  state_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 w_finish;

  // The finishing cycle performs no iteration; it only publishes the result.
`ifdef MATH_MULT_EARLY_EXIT_EN
  assign w_finish = (cnt_q == CNT_W'(WIDTH)) || (mplier_q == '0);
`else
  assign w_finish = (cnt_q == CNT_W'(WIDTH));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d  = S_RUN;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        if (w_finish) begin
          state_d  = S_DONE;
          result_d = acc_q;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign mulResult = result_q;

endmodule : math_multiplier_seq

`default_nettype wire
